csa_mult_pipe: RTL and testbench
================================

Name: csa_mult_pipe

Overview:
- Parametrised, pipelined Wallace/carry-save multiplier functional unit for the Tomasulo execution cluster.
- Successor to the fixed 32-bit combinational CSA tree. Adds:
  - generic operand width;
  - signed/unsigned mode;
  - a 3-stage registered pipeline with valid/ready handshake;
  - reservation-station tag pass-through;
  - flush.
- Sits between the multiply reservation station and the CDB arbiter.

Parameters:
- WIDTH, 32, operand width in bits (>= 4, even).
- TAG_W, 4, width of the reservation-station tag carried with each operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all in-flight operations (branch mispredict / exception).
- in_valid  input  1  operands and tag presented.
- in_ready  output  1  unit can accept an operation this cycle.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  reservation-station tag.
- out_valid  output  1  product valid.
- out_ready  input  1  CDB arbiter accepts the product.
- out_product  output  2*WIDTH  full-width product.
- out_tag  output  TAG_W  tag of out_product.
- busy  output  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset and clock: one clock (clk); reset (rst) is synchronous and active-high. Reset clears all stage valid bits.
  - Reset values: out_valid=0, out_product=0, out_tag=0, busy=0.
  - in_ready=1 in the cycle after reset deasserts.
- Accept rule: an operation is accepted when in_valid && in_ready at a clock edge.
- Pipeline stages, each with its own valid bit v1/v2/v3:
  - S1: register in_a, in_b, in_signed, in_tag.
  - S2: generate WIDTH partial products and reduce them with 3:2 full-adder CSA levels to two 2*WIDTH vectors (sum, carry). Register both vectors.
    - Signed mode: sign-extend operands to WIDTH+1 bits. Use a Baugh-Wooley-equivalent correction; any correct two's-complement scheme is acceptable.
    - Carry vector bit 0 = 0.
  - S3: carry-propagate add sum+carry, truncate to 2*WIDTH, register into out_product.
- Latency: exactly 3 cycles. An operation accepted at edge N gives out_valid=1 from after edge N+3, provided no stall.
- Throughput: 1 operation per cycle when out_ready stays high.
- Stall: global stall = out_valid && !out_ready.
  - During a stall all stages hold their contents and in_ready=0.
  - in_ready = !stall (combinational).
  - out_product and out_tag stay stable while out_valid && !out_ready.
- Bubbles: an invalid stage may be overwritten even during a stall, but stall-all is acceptable and is the required implementation.
- Flush: at the edge where flush=1, clear v1, v2 and v3 (out_valid=0 next cycle).
  - An input offered in the same cycle is dropped; in_ready is still driven as normal.
  - flush has priority over accept and stall.
  - rst has priority over flush.
- busy = v1 | v2 | v3.
- Arithmetic:
  - unsigned: out_product = in_a * in_b, exact over 2*WIDTH bits.
  - signed: out_product = exact two's-complement product over 2*WIDTH bits, including the most-negative × most-negative case.
- Data registers need no reset except out_product and out_tag. Valid bits must be reset.

Test Plan:
1. Unsigned max: WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF, signed=0, tag=3, out_ready=1.
   - Expect out_product=0xFFFFFFFE00000001 and out_tag=3, exactly 3 cycles after accept.
2. Signed corners: send back-to-back, one per cycle:
   - (-1)*(-1) → 0x0000000000000001
   - 0x80000000*0x80000000 → 0x4000000000000000
   - 0xFFFFFFFF*2 → 0xFFFFFFFFFFFFFFFE
   - 0x7FFFFFFF*0x80000000 → 0xC000000080000000
   - Expect four consecutive out_valid cycles, in order, with tags 0..3.
3. Backpressure: stream 5 ops, drop out_ready for 4 cycles mid-stream.
   - Expect in_ready=0 while stalled and out_product/out_tag held stable.
   - No loss or duplication; all 5 results delivered in order.
4. Flush: accept 3 ops on consecutive cycles, assert flush for 1 cycle on the cycle after the third accept.
   - Expect out_valid never asserts for those 3 and busy=0 the next cycle.
   - A new op accepted after flush returns its correct result 3 cycles later.
5. Reset mid-operation: assert rst with 3 ops in flight and out_valid=1, out_ready=0.
   - Next cycle: out_valid=0, out_product=0, busy=0.
   - No stale result appears afterwards.
6. Randomised sweep at WIDTH=8 and WIDTH=32: random signed/unsigned ops, random out_ready and flush.
   - Scoreboard compares every result and tag against a reference multiply.

Source files
------------

// File: rtl/csa_mult_pipe.sv
// Pipelined carry-save multiplier for the Tomasulo multiply unit: operand register,
// partial-product generation with 3:2 reduction, and a split carry-propagate add.
module csa_mult_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int unsigned NPP = WIDTH;
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] CORR = {{(PW-1){1'b0}}, 1'b1} << (WIDTH - 1);

    logic stall;
    logic v1, v2, v3, vo;

    logic [WIDTH-1:0] a1, b1;
    logic             sg1;
    logic [TAG_W-1:0] t1, t2, t3;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] rows [WIDTH+1];
    logic [PW-1:0] s_acc, c_acc, t_sum;
    logic [PW-1:0] sum2, carry2;

    logic [WIDTH:0]   lo_add;
    logic [WIDTH-1:0] lo3, hs3, hc3;
    logic             cy3;

    assign stall     = vo && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vo;
    assign busy      = v1 | v2 | v3 | vo;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            vo <= 1'b0;
        end else if (!stall) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            vo <= v3;
        end
    end

    // Signed: the multiplier's top bit weighs -2^(W-1), so that row is
    // ~a_ext << (W-1) plus a constant 2^(W-1) correction row.
    always_comb begin
        a_ext = {{WIDTH{sg1 & a1[WIDTH-1]}}, a1};
        for (int unsigned i = 0; i < NPP; i++) begin
            if (sg1 && (i == NPP - 1))
                rows[i] = b1[i] ? ((~a_ext) << i) : '0;
            else
                rows[i] = b1[i] ? (a_ext << i) : '0;
        end
        rows[WIDTH] = (sg1 && b1[WIDTH-1]) ? CORR : '0;
        s_acc = rows[0];
        c_acc = '0;
        t_sum = '0;
        for (int unsigned i = 1; i <= NPP; i++) begin
            t_sum = s_acc ^ c_acc ^ rows[i];
            c_acc = ((s_acc & c_acc) | (s_acc & rows[i]) | (c_acc & rows[i])) << 1;
            s_acc = t_sum;
        end
    end

    // Final add is split low/high across two registers, giving 3 cycles accept-to-valid.
    assign lo_add = {1'b0, sum2[WIDTH-1:0]} + {1'b0, carry2[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (!stall) begin
            a1     <= in_a;
            b1     <= in_b;
            sg1    <= in_signed;
            t1     <= in_tag;
            sum2   <= s_acc;
            carry2 <= c_acc;
            t2     <= t1;
            lo3    <= lo_add[WIDTH-1:0];
            cy3    <= lo_add[WIDTH];
            hs3    <= sum2[PW-1:WIDTH];
            hc3    <= carry2[PW-1:WIDTH];
            t3     <= t2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_product <= '0;
            out_tag     <= '0;
        end else if (!stall) begin
            out_product <= {hs3 + hc3 + {{(WIDTH-1){1'b0}}, cy3}, lo3};
            out_tag     <= t3;
        end
    end
endmodule

// File: tb/tb_csa_mult_pipe.sv
// Directed-vector and scoreboard bench for csa_mult_pipe at WIDTH=32 and WIDTH=8.
module tb_csa_mult_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [63:0] out_product;

    logic flush8, in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_a8, in_b8;
    logic [3:0]  in_tag8, out_tag8;
    logic [15:0] out_product8;

    csa_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_tag(out_tag), .busy(busy)
    );

    csa_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_signed(in_signed8), .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_product(out_product8),
        .out_tag(out_tag8), .busy(busy8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [12];

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
    } exp_t;
    exp_t q32 [$];
    exp_t q8  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        return sa * sb;
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {8'b0, a};
            sb = {8'b0, b};
        end
        return sa * sb;
    endfunction

    // Scoreboards: the values seen at a falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        exp_t e;
        if (rst) q32.delete();
        else begin
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb32_extra: got product %h with nothing outstanding, expected none", out_product);
                end else begin
                    e = q32.pop_front();
                    chk("sb32_product", out_product, e.p);
                    chk("sb32_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (flush) q32.delete();
            else if (in_valid && in_ready) q32.push_back('{ref32(in_signed, in_a, in_b), in_tag});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) q8.delete();
        else begin
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb8_extra: got product %h with nothing outstanding, expected none", out_product8);
                end else begin
                    e = q8.pop_front();
                    chk("sb8_product", 64'(out_product8), e.p);
                    chk("sb8_tag", 64'(out_tag8), 64'(e.tag));
                end
            end
            if (flush8) q8.delete();
            else if (in_valid8 && in_ready8)
                q8.push_back('{64'(ref8(in_signed8, in_a8, in_b8)), in_tag8});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_signed = v.s;
        in_a      = v.a;
        in_b      = v.b;
        in_tag    = v.tag;
    endtask

    task automatic run_burst(input int lo, input int hi);
        int n;
        n = hi - lo + 1;
        for (int j = 0; j < n + 5; j++) begin
            if (j < n) drive(vecs[lo + j]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (j < n) chk("burst_in_ready", 64'(in_ready), 64'd1);
            if (j >= 4 && j - 4 < n) begin
                chk("burst_valid", 64'(out_valid), 64'd1);
                chk("burst_product", out_product, vecs[lo + j - 4].exp);
                chk("burst_tag", 64'(out_tag), 64'(vecs[lo + j - 4].tag));
            end else begin
                chk("burst_idle", 64'(out_valid), 64'd0);
            end
            step();
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'hFF;
            2: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int idx;
        int eo;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3,  64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0,  64'h0000_0000_0000_0001};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 4'd1,  64'h4000_0000_0000_0000};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 4'd2,  64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4]  = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd3,  64'hC000_0000_8000_0000};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 4'd5,  64'hFFFF_FFFF_FFFF_FFF1};
        vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'd6,  64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 4'd7,  64'h0000_0001_0000_0000};
        vecs[8]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 4'd8,  64'h0000_0001_2345_6780};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd9,  64'h3FFF_FFFF_0000_0001};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 4'd10, 64'h0000_0000_0000_0000};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 4'd11, 64'h4000_0000_0000_0000};

        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        flush8 = 1'b0; in_valid8 = 1'b0; in_signed8 = 1'b0; in_a8 = '0; in_b8 = '0; in_tag8 = '0;
        out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_product", out_product, 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        step();

        run_burst(0, 0);
        run_burst(1, 4);
        run_burst(5, 11);

        // Backpressure: output stalls for 4 cycles while op4 waits at the input.
        idx = 0;
        for (int j = 0; j < 14; j++) begin
            out_ready = !(j >= 4 && j <= 7);
            if (idx < 5) drive(vecs[5 + idx]);
            else in_valid = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), (j >= 4 && j <= 7) ? 64'd0 : 64'd1);
            eo = (j >= 4 && j <= 8) ? 0 : (j >= 9 && j <= 12) ? j - 8 : -1;
            if (eo >= 0) begin
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_product", out_product, vecs[5 + eo].exp);
                chk("bp_tag", 64'(out_tag), 64'(vecs[5 + eo].tag));
            end else begin
                chk("bp_idle", 64'(out_valid), 64'd0);
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        chk("bp_all_accepted", 64'(idx), 64'd5);

        // Flush after three accepts; the op offered with the flush is dropped.
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            flush = (j == 3);
            if (j < 3) drive(vecs[1 + j]);
            else if (j == 3) drive(vecs[5]);
            else if (j == 4) drive(vecs[0]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (j == 3) chk("flush_in_ready", 64'(in_ready), 64'd1);
            if (j == 4) chk("flush_busy", 64'(busy), 64'd0);
            if (j == 8) begin
                chk("flush_new_valid", 64'(out_valid), 64'd1);
                chk("flush_new_product", out_product, vecs[0].exp);
                chk("flush_new_tag", 64'(out_tag), 64'(vecs[0].tag));
            end else begin
                chk("flush_no_valid", 64'(out_valid), 64'd0);
            end
            step();
        end
        flush = 1'b0;

        // Reset while stalled with a full pipeline.
        for (int j = 0; j < 13; j++) begin
            rst = (j == 4);
            out_ready = (j >= 5);
            if (j < 4) drive(vecs[1 + j]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (j == 4) begin
                chk("rst_pre_valid", 64'(out_valid), 64'd1);
                chk("rst_pre_busy", 64'(busy), 64'd1);
            end
            if (j == 5) begin
                chk("rst_out_product", out_product, 64'd0);
                chk("rst_out_tag", 64'(out_tag), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
            end
            if (j >= 5) chk("rst_no_stale", 64'(out_valid), 64'd0);
            step();
        end
        rst = 1'b0;

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_signed = 1'($urandom_range(0, 1));
            in_a      = pick32();
            in_b      = pick32();
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("sb32_drained", 64'(q32.size()), 64'd0);
        chk("sb32_idle_busy", 64'(busy), 64'd0);
        step();

        for (int c = 0; c < 600; c++) begin
            in_valid8  = ($urandom_range(0, 9) < 7);
            in_signed8 = 1'($urandom_range(0, 1));
            in_a8      = pick8();
            in_b8      = pick8();
            in_tag8    = 4'($urandom);
            out_ready8 = ($urandom_range(0, 3) != 0);
            flush8     = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("sb8_drained", 64'(q8.size()), 64'd0);
        chk("sb8_idle_busy", 64'(busy8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
